aib_mac_link_seq: RTL and testbench

AIB_MAC_LINK_SEQ -- requirements
Module: aib_mac_link_seq

---
 rtl/aib_mac_link_seq.sv | 181 ++++++++++++++++++
 tb/tb_aib_mac_link_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aib_mac_link_seq.sv
// AIB MAC link bring-up sequencer.
// Walks the near-side adapter through reset hold, MAC ready, DCC/DLL lock,
// word alignment and link-up. It retrains on link loss or on too many
// word-align errors.
// Optional feature macro: AIB_LINK_SEQ_TIMEOUT_EN. When it is defined, the
// MACRDY/LOCK/ALIGN wait states give up after TIMEOUT cycles, retrain, and
// set the sticky o_timeout flag. When it is undefined, those states wait
// indefinitely and o_timeout is tied low.
module aib_mac_link_seq #(
  parameter int unsigned RST_HOLD   = 16,
  parameter int unsigned WA_ERR_MAX = 8,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic       i_osc_clk,
  input  logic       i_rst,
  input  logic       i_conf_done,
  input  logic       i_fs_mac_rdy,
  input  logic       i_tx_transfer_en,
  input  logic       i_rx_transfer_en,
  input  logic       i_rxfifo_align_done,
  input  logic       i_wa_error,
  output logic       o_ns_adapter_rstn,
  output logic       o_ns_mac_rdy,
  output logic       o_dcc_dll_lock_req,
  output logic       o_link_up,
  output logic [3:0] o_wa_error_cnt,
  output logic [7:0] o_retrain_cnt,
  output logic       o_timeout,
  output logic [2:0] o_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RSTHOLD = 3'd1;
  localparam logic [2:0] S_MACRDY  = 3'd2;
  localparam logic [2:0] S_LOCK    = 3'd3;
  localparam logic [2:0] S_ALIGN   = 3'd4;
  localparam logic [2:0] S_LINKUP  = 3'd5;
  localparam logic [2:0] S_RETRAIN = 3'd6;

  // Wait-counter value seen on the last cycle of the reset hold.
  localparam logic [15:0] LP_HOLD_LAST = 16'(RST_HOLD - 1);
  localparam logic [3:0]  LP_WA_MAX    = 4'(WA_ERR_MAX);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [15:0] r_wait_cnt;
  logic [3:0]  r_wa_cnt;
  logic [7:0]  r_retrain_cnt;
  logic        r_rstn;
  logic        r_mac_rdy;
  logic        r_lock_req;
  logic        r_link_up;
  logic        w_link_loss;
  logic        w_err_hit;
  logic        w_timeout_hit;

  // Far-side MAC loss matters once lock is requested.
  // Transfer-enable loss matters once alignment has started.
  assign w_link_loss =
      (((r_state == S_LOCK) || (r_state == S_ALIGN) || (r_state == S_LINKUP)) && !i_fs_mac_rdy) ||
      (((r_state == S_ALIGN) || (r_state == S_LINKUP)) && !(i_tx_transfer_en && i_rx_transfer_en));

  assign w_err_hit = (r_state == S_LINKUP) && (r_wa_cnt == LP_WA_MAX);

`ifdef AIB_LINK_SEQ_TIMEOUT_EN
  // Wait-counter value on the TIMEOUT-th cycle spent in a wait state.
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT - 1);
  logic r_timeout;

  assign w_timeout_hit =
      ((r_state == S_MACRDY) || (r_state == S_LOCK) || (r_state == S_ALIGN)) &&
      (r_wait_cnt == LP_TO_LAST);

  // Sticky timeout flag; set only when the timeout is what forces the retrain.
  always_ff @(posedge i_osc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timeout <= 1'b0;
    end else if (i_conf_done && !w_link_loss && !w_err_hit && w_timeout_hit) begin
      r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT);
  assign w_timeout_hit    = 1'b0;
  assign o_timeout        = 1'b0;
`endif

  // Next-state selection: config loss, then link loss, then error
  // threshold, then timeout, then normal forward progress.
  always_comb begin
    w_state_next = r_state;
    if ((r_state != S_IDLE) && !i_conf_done) begin
      w_state_next = S_IDLE;
    end else if (w_link_loss || w_err_hit || w_timeout_hit) begin
      w_state_next = S_RETRAIN;
    end else begin
      case (r_state)
        S_IDLE:    if (i_conf_done) w_state_next = S_RSTHOLD;
        S_RSTHOLD: if (r_wait_cnt == LP_HOLD_LAST) w_state_next = S_MACRDY;
        S_MACRDY:  if (i_fs_mac_rdy) w_state_next = S_LOCK;
        S_LOCK:    if (i_tx_transfer_en && i_rx_transfer_en) w_state_next = S_ALIGN;
        S_ALIGN:   if (i_rxfifo_align_done) w_state_next = S_LINKUP;
        S_LINKUP:  w_state_next = S_LINKUP;
        S_RETRAIN: w_state_next = S_RSTHOLD;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_osc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Shared wait counter: restarts on every state change and saturates.
  always_ff @(posedge i_osc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != 16'hFFFF) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  // Word-align error count.
  // It restarts when alignment begins and saturates at 15 while the link is up.
  always_ff @(posedge i_osc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wa_cnt <= '0;
    end else if ((w_state_next == S_ALIGN) && (r_state != S_ALIGN)) begin
      r_wa_cnt <= '0;
    end else if ((r_state == S_LINKUP) && i_wa_error && (r_wa_cnt != 4'hF)) begin
      r_wa_cnt <= r_wa_cnt + 4'd1;
    end
  end

  // Retrain entry counter, saturating at 255.
  always_ff @(posedge i_osc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_retrain_cnt <= '0;
    end else if ((w_state_next == S_RETRAIN) && (r_state != S_RETRAIN) &&
                 (r_retrain_cnt != 8'hFF)) begin
      r_retrain_cnt <= r_retrain_cnt + 8'd1;
    end
  end

  // Output controls decoded from the next state.
  // They therefore change on the same edge as o_state.
  always_ff @(posedge i_osc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rstn     <= 1'b0;
      r_mac_rdy  <= 1'b0;
      r_lock_req <= 1'b0;
      r_link_up  <= 1'b0;
    end else begin
      r_rstn     <= (w_state_next != S_IDLE) && (w_state_next != S_RSTHOLD);
      r_mac_rdy  <= (w_state_next == S_MACRDY) || (w_state_next == S_LOCK) ||
                    (w_state_next == S_ALIGN)  || (w_state_next == S_LINKUP);
      r_lock_req <= (w_state_next == S_LOCK) || (w_state_next == S_ALIGN) ||
                    (w_state_next == S_LINKUP);
      r_link_up  <= (w_state_next == S_LINKUP);
    end
  end

  assign o_ns_adapter_rstn  = r_rstn;
  assign o_ns_mac_rdy       = r_mac_rdy;
  assign o_dcc_dll_lock_req = r_lock_req;
  assign o_link_up          = r_link_up;
  assign o_wa_error_cnt     = r_wa_cnt;
  assign o_retrain_cnt      = r_retrain_cnt;
  assign o_state            = r_state;

endmodule

// File: tb/tb_aib_mac_link_seq.sv
// Testbench for aib_mac_link_seq.
// Two instances share the inputs:
//   - u0 uses RST_HOLD=16, WA_ERR_MAX=8, TIMEOUT=100.
//   - u1 uses RST_HOLD=3, WA_ERR_MAX=15, TIMEOUT=100.
// A cycle-based reference model tracks the state, the time spent in the
// current state, and the counters. Directed steps run first, then a
// randomized segment follows.
`timescale 1ns/1ps
module tb_aib_mac_link_seq;

  localparam int S_IDLE    = 0;
  localparam int S_RSTHOLD = 1;
  localparam int S_MACRDY  = 2;
  localparam int S_LOCK    = 3;
  localparam int S_ALIGN   = 4;
  localparam int S_LINKUP  = 5;
  localparam int S_RETRAIN = 6;
  localparam int TMO       = 100;
`ifdef AIB_LINK_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic conf = 1'b0, fs = 1'b0, tx = 1'b0, rx = 1'b0, align = 1'b0, wa = 1'b0;

  logic [1:0] rstn_o, mac_o, lock_o, link_o, to_o;
  logic [3:0] wa_o  [2];
  logic [7:0] rtr_o [2];
  logic [2:0] st_o  [2];

  int p_hold  [2] = '{16, 3};
  int p_wamax [2] = '{8, 15};

  // Reference model state per instance.
  int m_state [2];
  int m_age   [2];
  int m_wa    [2];
  int m_rtr   [2];
  int m_to    [2];

  int checks = 0;
  int errors = 0;
  int exp_st;
  int exp_to;

  always #5 clk = ~clk;

  aib_mac_link_seq #(.RST_HOLD(16), .WA_ERR_MAX(8), .TIMEOUT(TMO)) u0 (
    .i_osc_clk(clk), .i_rst(rst), .i_conf_done(conf), .i_fs_mac_rdy(fs),
    .i_tx_transfer_en(tx), .i_rx_transfer_en(rx), .i_rxfifo_align_done(align),
    .i_wa_error(wa), .o_ns_adapter_rstn(rstn_o[0]), .o_ns_mac_rdy(mac_o[0]),
    .o_dcc_dll_lock_req(lock_o[0]), .o_link_up(link_o[0]), .o_wa_error_cnt(wa_o[0]),
    .o_retrain_cnt(rtr_o[0]), .o_timeout(to_o[0]), .o_state(st_o[0])
  );

  aib_mac_link_seq #(.RST_HOLD(3), .WA_ERR_MAX(15), .TIMEOUT(TMO)) u1 (
    .i_osc_clk(clk), .i_rst(rst), .i_conf_done(conf), .i_fs_mac_rdy(fs),
    .i_tx_transfer_en(tx), .i_rx_transfer_en(rx), .i_rxfifo_align_done(align),
    .i_wa_error(wa), .o_ns_adapter_rstn(rstn_o[1]), .o_ns_mac_rdy(mac_o[1]),
    .o_dcc_dll_lock_req(lock_o[1]), .o_link_up(link_o[1]), .o_wa_error_cnt(wa_o[1]),
    .o_retrain_cnt(rtr_o[1]), .o_timeout(to_o[1]), .o_state(st_o[1])
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic mreset(input int k);
    m_state[k] = S_IDLE;
    m_age[k]   = 0;
    m_wa[k]    = 0;
    m_rtr[k]   = 0;
    m_to[k]    = 0;
  endtask

  // One clock edge of the link rules, using the inputs sampled at that edge.
  task automatic mstep(input int k);
    int s;
    int ns;
    int age;
    bit loss;
    bit thr;
    bit tmo;
    s    = m_state[k];
    ns   = s;
    age  = m_age[k] + 1;
    loss = ((s == S_LOCK || s == S_ALIGN || s == S_LINKUP) && !fs) ||
           ((s == S_ALIGN || s == S_LINKUP) && !(tx && rx));
    thr  = (s == S_LINKUP) && (m_wa[k] == p_wamax[k]);
    tmo  = TO_EN && (s == S_MACRDY || s == S_LOCK || s == S_ALIGN) && (age >= TMO);
    if (s != S_IDLE && !conf) ns = S_IDLE;
    else if (loss || thr) ns = S_RETRAIN;
    else if (tmo) begin
      ns = S_RETRAIN;
      m_to[k] = 1;
    end else begin
      case (s)
        S_IDLE:    if (conf) ns = S_RSTHOLD;
        S_RSTHOLD: if (age == p_hold[k]) ns = S_MACRDY;
        S_MACRDY:  if (fs) ns = S_LOCK;
        S_LOCK:    if (tx && rx) ns = S_ALIGN;
        S_ALIGN:   if (align) ns = S_LINKUP;
        S_RETRAIN: ns = S_RSTHOLD;
        default:   ns = s;
      endcase
    end
    if (s == S_LINKUP && wa && m_wa[k] < 15) m_wa[k]++;
    if (ns == S_ALIGN && s != S_ALIGN) m_wa[k] = 0;
    if (ns == S_RETRAIN && m_rtr[k] < 255) m_rtr[k]++;
    m_age[k]   = (ns == s) ? age : 0;
    m_state[k] = ns;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int s;
      s = m_state[k];
      chk($sformatf("u%0d_state", k), 16'(st_o[k]), 16'(s));
      chk($sformatf("u%0d_rstn", k), 16'(rstn_o[k]), 16'(s != S_IDLE && s != S_RSTHOLD));
      chk($sformatf("u%0d_macrdy", k), 16'(mac_o[k]), 16'(s >= S_MACRDY && s <= S_LINKUP));
      chk($sformatf("u%0d_lockreq", k), 16'(lock_o[k]), 16'(s >= S_LOCK && s <= S_LINKUP));
      chk($sformatf("u%0d_linkup", k), 16'(link_o[k]), 16'(s == S_LINKUP));
      chk($sformatf("u%0d_wacnt", k), 16'(wa_o[k]), 16'(m_wa[k]));
      chk($sformatf("u%0d_rtrcnt", k), 16'(rtr_o[k]), 16'(m_rtr[k]));
      chk($sformatf("u%0d_timeout", k), 16'(to_o[k]), 16'(m_to[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) mreset(k);
      else mstep(k);
    end
    #1;
    check_all();
  endtask

  task automatic wait_u0(input int target, input int budget, input string tag);
    for (int n = 0; n < budget && m_state[0] != target; n++) tick();
    chk(tag, 16'(st_o[0]), 16'(target));
  endtask

  initial begin
    mreset(0);
    mreset(1);
    #1 rst = 1'b1;
    #1;
    // Reset values before any clock edge.
    check_all();
    chk("rst_rstn", 16'(rstn_o[0]), 16'd0);
    $display("step reset state=%0d", st_o[0]);

    // conf_done already high while reset is held: IDLE must persist.
    conf = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release_idle", 16'(st_o[0]), 16'(S_IDLE));
    tick();
    chk("enter_rsthold", 16'(st_o[0]), 16'(S_RSTHOLD));

    // Reset hold: rstn stays low for 15 more edges and rises on the 16th.
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("hold_rstn_low", 16'(rstn_o[0]), 16'd0);
    end
    tick();
    chk("hold_rstn_high", 16'(rstn_o[0]), 16'd1);
    chk("enter_macrdy", 16'(st_o[0]), 16'(S_MACRDY));
    $display("step rsthold done state=%0d", st_o[0]);

    fs = 1'b1;
    tick();
    chk("enter_lock", 16'(st_o[0]), 16'(S_LOCK));
    tx = 1'b1;
    rx = 1'b1;
    tick();
    chk("enter_align", 16'(st_o[0]), 16'(S_ALIGN));
    align = 1'b1;
    tick();
    chk("enter_linkup", 16'(st_o[0]), 16'(S_LINKUP));
    chk("linkup_flag", 16'(link_o[0]), 16'd1);
    $display("step bring-up state=%0d link_up=%0d", st_o[0], link_o[0]);

    // Eight word-align errors reach the threshold of u0.
    wa = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    wa = 1'b0;
    chk("wa_cnt_8", 16'(wa_o[0]), 16'd8);
    chk("wa_still_up", 16'(st_o[0]), 16'(S_LINKUP));
    tick();
    chk("wa_retrain", 16'(st_o[0]), 16'(S_RETRAIN));
    chk("wa_rtr_cnt", 16'(rtr_o[0]), 16'd1);
    tick();
    chk("wa_rsthold", 16'(st_o[0]), 16'(S_RSTHOLD));
    $display("step err threshold retrain_cnt=%0d", rtr_o[0]);

    // Keep pulsing: u1 (threshold 15) saturates at 15.
    wa = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    wa = 1'b0;
    chk("wa15_sat", 16'(wa_o[1]), 16'd15);
    $display("step wa saturate u1_cnt=%0d", wa_o[1]);

    wait_u0(S_LINKUP, 60, "relink_1");
    chk("wa_cleared", 16'(wa_o[0]), 16'd0);

    // Link loss: RX transfer enable drops.
    rx = 1'b0;
    tick();
    chk("loss_retrain", 16'(st_o[0]), 16'(S_RETRAIN));
    chk("loss_linkup0", 16'(link_o[0]), 16'd0);
    tick();
    chk("loss_rsthold", 16'(st_o[0]), 16'(S_RSTHOLD));
    $display("step link loss state=%0d", st_o[0]);
    rx = 1'b1;
    wait_u0(S_LINKUP, 60, "relink_2");

    // conf_done and fs_mac_rdy fall together: IDLE wins over RETRAIN.
    conf = 1'b0;
    fs = 1'b0;
    tick();
    chk("prio_idle", 16'(st_o[0]), 16'(S_IDLE));
    chk("prio_idle_u1", 16'(st_o[1]), 16'(S_IDLE));
    $display("step priority state=%0d", st_o[0]);

    // Park in MACRDY with fs_mac_rdy low.
    conf = 1'b1;
    wait_u0(S_MACRDY, 40, "to_macrdy");
    for (int i = 1; i < TMO; i++) tick();
    chk("to_still_wait", 16'(st_o[0]), 16'(S_MACRDY));
    tick();
    exp_st = TO_EN ? S_RETRAIN : S_MACRDY;
    exp_to = TO_EN ? 1 : 0;
    chk("to_state", 16'(st_o[0]), 16'(exp_st));
    chk("to_flag", 16'(to_o[0]), 16'(exp_to));
    $display("step timeout state=%0d timeout=%0d", st_o[0], to_o[0]);

    // Reach LOCK, then assert reset mid-cycle.
    tx = 1'b0;
    rx = 1'b0;
    fs = 1'b1;
    wait_u0(S_LOCK, 40, "to_lock");
    #3 rst = 1'b1;
    #1;
    chk("rl_state", 16'(st_o[0]), 16'(S_IDLE));
    chk("rl_rstn", 16'(rstn_o[0]), 16'd0);
    chk("rl_macrdy", 16'(mac_o[0]), 16'd0);
    chk("rl_lockreq", 16'(lock_o[0]), 16'd0);
    chk("rl_rtrcnt", 16'(rtr_o[0]), 16'd0);
    chk("rl_wacnt", 16'(wa_o[0]), 16'd0);
    chk("rl_timeout", 16'(to_o[0]), 16'd0);
    $display("step reset in lock state=%0d", st_o[0]);
    tick();
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      conf  = ($urandom_range(99) < 97);
      fs    = ($urandom_range(99) < 95);
      tx    = ($urandom_range(99) < 96);
      rx    = ($urandom_range(99) < 96);
      align = ($urandom_range(1) == 1);
      wa    = ($urandom_range(4) == 0);
      rst   = ($urandom_range(199) == 0);
      tick();
    end
    $display("step random done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
